mem_req_arbiter: RTL and testbench

//  N-client arbiter between cache refill/writeback ports and the single main-memory port (ExtMemModel).

---
 rtl/mem_req_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Purpose: arbitrates N cache clients onto one main-memory port, forwards write bursts, routes read responses by tag.
// Latency: 1 cycle from client valid to mem_req_valid; response routing is combinational.
// Backpressure: mem_req_ready/mem_req_data_ready pass straight to the granted client; reads stall at MAX_OUTSTANDING.
module mem_req_arbiter #(
    parameter int N_CLIENTS       = 2,
    parameter int ADDR_BITS       = 28,
    parameter int TAG_BITS        = 5,
    parameter int DATA_BITS       = 128,
    parameter int BEATS           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PRIORITY_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_CLIENTS-1:0]             cl_req_valid,
    output logic [N_CLIENTS-1:0]             cl_req_ready,
    input  logic [N_CLIENTS-1:0]             cl_req_rw,
    input  logic [N_CLIENTS*ADDR_BITS-1:0]   cl_req_addr,
    input  logic [N_CLIENTS-1:0]             cl_req_data_valid,
    output logic [N_CLIENTS-1:0]             cl_req_data_ready,
    input  logic [N_CLIENTS*DATA_BITS-1:0]   cl_req_data_bits,
    input  logic [N_CLIENTS*DATA_BITS/8-1:0] cl_req_data_mask,
    output logic [N_CLIENTS-1:0]             cl_resp_valid,
    output logic [DATA_BITS-1:0]             cl_resp_data,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_rw,
    output logic [ADDR_BITS-1:0]             mem_req_addr,
    output logic [TAG_BITS-1:0]              mem_req_tag,
    output logic                             mem_req_data_valid,
    input  logic                             mem_req_data_ready,
    output logic [DATA_BITS-1:0]             mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]           mem_req_data_mask,
    input  logic                             mem_resp_valid,
    input  logic [DATA_BITS-1:0]             mem_resp_data,
    input  logic [TAG_BITS-1:0]              mem_resp_tag
);

    localparam int IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MASK_BITS = DATA_BITS / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    typedef struct packed {
        logic                 rw;
        logic [ADDR_BITS-1:0] addr;
    } hdr_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [MASK_BITS-1:0] mask;
    } beat_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [OUT_W-1:0]   outstanding_q;
    logic [BEAT_W-1:0]  beat_cnt_q;
    logic [BEAT_W-1:0]  resp_cnt_q;

    logic [N_CLIENTS-1:0] elig;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int                   cand;
    logic [IDX_W-1:0]     cand_idx;

    hdr_t  sel_hdr;
    beat_t sel_beat;
    logic  req_hs;
    logic  dat_hs;
    logic  dat_last;
    logic  rd_issue;
    logic  rsp_last;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            elig[i] = cl_req_valid[i] &
                      (cl_req_rw[i] | (outstanding_q < OUT_W'(MAX_OUTSTANDING)));
        end
    end

    // Scan from rr_ptr with wrap in round-robin mode, from client 0 in fixed mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand = (PRIORITY_MODE != 0) ? k : int'(rr_ptr_q) + k;
            if (cand >= N_CLIENTS) begin
                cand = cand - N_CLIENTS;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && elig[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_hdr.rw     = cl_req_rw[grant_q];
        sel_hdr.addr   = cl_req_addr[int'(grant_q)*ADDR_BITS +: ADDR_BITS];
        sel_beat.data  = cl_req_data_bits[int'(grant_q)*DATA_BITS +: DATA_BITS];
        sel_beat.mask  = cl_req_data_mask[int'(grant_q)*MASK_BITS +: MASK_BITS];
    end

    assign req_hs   = mem_req_valid & mem_req_ready;
    assign dat_hs   = mem_req_data_valid & mem_req_data_ready;
    assign dat_last = dat_hs & (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign rd_issue = req_hs & ~sel_hdr.rw;
    assign rsp_last = mem_resp_valid & ~reset & (resp_cnt_q == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mem_req_ready) state_d = sel_hdr.rw ? ST_WDATA : ST_IDLE;
            end
            ST_WDATA: begin
                if (dat_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every handshake output is forced low while reset is held.
    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        cl_req_ready       = '0;
        cl_req_data_ready  = '0;
        if (!reset) begin
            case (state_q)
                ST_ISSUE: begin
                    mem_req_valid         = 1'b1;
                    cl_req_ready[grant_q] = mem_req_ready;
                end
                ST_WDATA: begin
                    mem_req_data_valid         = cl_req_data_valid[grant_q];
                    cl_req_data_ready[grant_q] = mem_req_data_ready;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_rw        = sel_hdr.rw;
    assign mem_req_addr      = sel_hdr.addr;
    assign mem_req_tag       = TAG_BITS'(grant_q);
    assign mem_req_data_bits = sel_beat.data;
    assign mem_req_data_mask = sel_beat.mask;

    // The whole tag is compared so tags naming a nonexistent client route nowhere.
    always_comb begin
        cl_resp_valid = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cl_resp_valid[i] = mem_resp_valid & ~reset & (mem_resp_tag == TAG_BITS'(i));
        end
    end

    assign cl_resp_data = mem_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            resp_cnt_q    <= '0;
        end else begin
            if (state_q == ST_IDLE && win_found) begin
                grant_q <= win_idx;
            end
            if (req_hs) begin
                rr_ptr_q <= (int'(grant_q) == N_CLIENTS - 1) ? '0 : grant_q + 1'b1;
            end
            if (dat_hs) begin
                beat_cnt_q <= dat_last ? '0 : beat_cnt_q + 1'b1;
            end
            if (mem_resp_valid) begin
                resp_cnt_q <= rsp_last ? '0 : resp_cnt_q + 1'b1;
            end
            if (rd_issue && !rsp_last) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!rd_issue && rsp_last && outstanding_q != '0) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench: a 2-client round-robin arbiter and a 4-client fixed-priority arbiter.
module tb_mem_req_arbiter;

    localparam int AB = 28;
    localparam int TB = 5;
    localparam int DB = 128;
    localparam int MB = DB / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: N=2, round-robin
    logic            rst_a;
    logic [1:0]      a_req_valid, a_req_ready, a_req_rw, a_dvalid, a_dready, a_resp_valid;
    logic [2*AB-1:0] a_req_addr;
    logic [2*DB-1:0] a_dbits;
    logic [2*MB-1:0] a_dmask;
    logic [DB-1:0]   a_resp_data, a_mdbits, a_mresp_data;
    logic            a_mreq_valid, a_mreq_ready, a_mreq_rw, a_mdvalid, a_mdready, a_mresp_valid;
    logic [AB-1:0]   a_mreq_addr;
    logic [TB-1:0]   a_mreq_tag, a_mresp_tag;
    logic [MB-1:0]   a_mdmask;

    // Instance B: N=4, fixed priority
    logic            rst_b;
    logic [3:0]      b_req_valid, b_req_ready, b_req_rw, b_dvalid, b_dready, b_resp_valid;
    logic [4*AB-1:0] b_req_addr;
    logic [4*DB-1:0] b_dbits;
    logic [4*MB-1:0] b_dmask;
    logic [DB-1:0]   b_resp_data, b_mdbits, b_mresp_data;
    logic            b_mreq_valid, b_mreq_ready, b_mreq_rw, b_mdvalid, b_mdready, b_mresp_valid;
    logic [AB-1:0]   b_mreq_addr;
    logic [TB-1:0]   b_mreq_tag, b_mresp_tag;
    logic [MB-1:0]   b_mdmask;

    mem_req_arbiter #(.N_CLIENTS(2), .ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB),
                      .BEATS(4), .MAX_OUTSTANDING(4), .PRIORITY_MODE(0)) dut_a (
        .clk(clk), .reset(rst_a),
        .cl_req_valid(a_req_valid), .cl_req_ready(a_req_ready), .cl_req_rw(a_req_rw),
        .cl_req_addr(a_req_addr), .cl_req_data_valid(a_dvalid), .cl_req_data_ready(a_dready),
        .cl_req_data_bits(a_dbits), .cl_req_data_mask(a_dmask),
        .cl_resp_valid(a_resp_valid), .cl_resp_data(a_resp_data),
        .mem_req_valid(a_mreq_valid), .mem_req_ready(a_mreq_ready), .mem_req_rw(a_mreq_rw),
        .mem_req_addr(a_mreq_addr), .mem_req_tag(a_mreq_tag),
        .mem_req_data_valid(a_mdvalid), .mem_req_data_ready(a_mdready),
        .mem_req_data_bits(a_mdbits), .mem_req_data_mask(a_mdmask),
        .mem_resp_valid(a_mresp_valid), .mem_resp_data(a_mresp_data), .mem_resp_tag(a_mresp_tag)
    );

    mem_req_arbiter #(.N_CLIENTS(4), .ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB),
                      .BEATS(4), .MAX_OUTSTANDING(4), .PRIORITY_MODE(1)) dut_b (
        .clk(clk), .reset(rst_b),
        .cl_req_valid(b_req_valid), .cl_req_ready(b_req_ready), .cl_req_rw(b_req_rw),
        .cl_req_addr(b_req_addr), .cl_req_data_valid(b_dvalid), .cl_req_data_ready(b_dready),
        .cl_req_data_bits(b_dbits), .cl_req_data_mask(b_dmask),
        .cl_resp_valid(b_resp_valid), .cl_resp_data(b_resp_data),
        .mem_req_valid(b_mreq_valid), .mem_req_ready(b_mreq_ready), .mem_req_rw(b_mreq_rw),
        .mem_req_addr(b_mreq_addr), .mem_req_tag(b_mreq_tag),
        .mem_req_data_valid(b_mdvalid), .mem_req_data_ready(b_mdready),
        .mem_req_data_bits(b_mdbits), .mem_req_data_mask(b_mdmask),
        .mem_resp_valid(b_mresp_valid), .mem_resp_data(b_mresp_data), .mem_resp_tag(b_mresp_tag)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int beat;
    logic rdy;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_req_valid = 2'b11; a_req_rw = 2'b00; a_dvalid = '0; a_dbits = '0; a_dmask = '0;
        a_req_addr = '0;
        a_req_addr[0*AB +: AB] = 28'h0001000;
        a_req_addr[1*AB +: AB] = 28'h0002000;
        a_mreq_ready = 1'b1; a_mdready = 1'b1;
        a_mresp_valid = 1'b0; a_mresp_data = '0; a_mresp_tag = '0;
        b_req_valid = '0; b_req_rw = '0; b_dvalid = '0; b_dbits = '0; b_dmask = '0;
        b_req_addr = '0;
        b_req_addr[1*AB +: AB] = 28'h0011000;
        b_req_addr[2*AB +: AB] = 28'h0022000;
        b_req_addr[3*AB +: AB] = 28'h0033000;
        b_mreq_ready = 1'b1; b_mdready = 1'b0;
        b_mresp_valid = 1'b0; b_mresp_data = '0; b_mresp_tag = '0;

        // Reset: clients requesting, nothing may leave the arbiter
        step(); step();
        chk("a_rst_mreq_valid", a_mreq_valid, 0);
        chk("a_rst_req_ready", a_req_ready, 0);
        chk("a_rst_outstanding", dut_a.outstanding_q, 0);
        rst_a = 1'b0;

        // RR alternation with both clients reading every cycle
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk("a_rr_valid", a_mreq_valid, 1);
            chk("a_rr_tag", a_mreq_tag, k % 2);
            chk("a_rr_addr", a_mreq_addr, (k % 2 == 0) ? 28'h0001000 : 28'h0002000);
            chk("a_rr_ready", a_req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            step(); #1;
            chk("a_rr_gap", a_mreq_valid, 0);
        end

        // Fifth read held at MAX_OUTSTANDING
        step(); #1;
        chk("a_hold_valid0", a_mreq_valid, 0);
        chk("a_hold_outst", dut_a.outstanding_q, 4);

        // Four response beats for tag 0 release one slot
        for (int k = 0; k < 4; k++) begin
            a_mresp_valid = 1'b1; a_mresp_tag = 5'd0; a_mresp_data = 128'h100 + 128'(k);
            #1;
            chk("a_resp_valid", a_resp_valid, 2'b01);
            chk("a_resp_data", a_resp_data, 128'h100 + 128'(k));
            chk("a_resp_hold", a_mreq_valid, 0);
            step();
        end
        a_mresp_valid = 1'b0;
        #1;
        chk("a_after_resp_idle", a_mreq_valid, 0);
        step(); #1;
        chk("a_fifth_valid", a_mreq_valid, 1);
        chk("a_fifth_tag", a_mreq_tag, 0);
        chk("a_fifth_rw", a_mreq_rw, 0);

        // Back at the limit: a write from client 0 still issues
        step();
        a_req_rw = 2'b01;
        a_dvalid = 2'b01;
        a_dmask[0 +: MB] = 16'hFFFF;
        a_dbits[0 +: DB] = 128'hA0;
        #1;
        chk("a_full_idle", a_mreq_valid, 0);
        step(); #1;
        chk("a_wr_valid", a_mreq_valid, 1);
        chk("a_wr_rw", a_mreq_rw, 1);
        chk("a_wr_tag", a_mreq_tag, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            a_dbits[0 +: DB] = 128'hA0 + 128'(k);
            #1;
            chk("a_wbeat_valid", a_mdvalid, 1);
            chk("a_wbeat_data", a_mdbits, 128'hA0 + 128'(k));
            chk("a_wbeat_ready", a_dready, 2'b01);
            step();
        end
        // Reset lands during beat 2
        a_dbits[0 +: DB] = 128'hA2;
        rst_a = 1'b1;
        #1;
        chk("a_rst_mid_dvalid", a_mdvalid, 0);
        step();
        rst_a = 1'b0;
        a_req_rw = 2'b00;
        a_dvalid = 2'b00;
        #1;
        chk("a_post_rst_dvalid", a_mdvalid, 0);
        chk("a_post_rst_state", dut_a.state_q, 0);
        chk("a_post_rst_outst", dut_a.outstanding_q, 0);
        chk("a_post_rst_rrptr", dut_a.rr_ptr_q, 0);
        step(); #1;
        // rr_ptr was 1 before reset; a restart at 0 grants client 0
        chk("a_post_rst_valid", a_mreq_valid, 1);
        chk("a_post_rst_tag", a_mreq_tag, 0);
        a_req_valid = 2'b00;

        // Fixed priority: clients 1 and 3 valid, client 1 wins until it drops
        rst_b = 1'b0;
        b_req_valid = 4'b1010;
        step(); #1;
        chk("b_fx_valid0", b_mreq_valid, 1);
        chk("b_fx_tag0", b_mreq_tag, 1);
        chk("b_fx_addr0", b_mreq_addr, 28'h0011000);
        step();
        step(); #1;
        chk("b_fx_tag1", b_mreq_tag, 1);
        chk("b_fx_ready1", b_req_ready, 4'b0010);
        step();
        b_req_valid = 4'b1000;
        step(); #1;
        chk("b_fx_valid3", b_mreq_valid, 1);
        chk("b_fx_tag3", b_mreq_tag, 3);
        chk("b_fx_addr3", b_mreq_addr, 28'h0033000);
        step();
        b_req_valid = 4'b0000;

        // Response routing by tag
        for (int k = 0; k < 4; k++) begin
            b_mresp_valid = 1'b1; b_mresp_tag = 5'd1; b_mresp_data = 128'hBEEF0 + 128'(k);
            #1;
            chk("b_resp1_valid", b_resp_valid, 4'b0010);
            chk("b_resp1_data", b_resp_data, 128'hBEEF0 + 128'(k));
            step();
        end
        for (int k = 0; k < 4; k++) begin
            b_mresp_valid = 1'b1; b_mresp_tag = (k == 0) ? 5'd4 : 5'd7;
            #1;
            chk("b_resp_bad_tag", b_resp_valid, 4'b0000);
            step();
        end
        b_mresp_valid = 1'b0;
        #1;
        chk("b_resp_none", b_resp_valid, 4'b0000);

        // Client 2 writes four beats with mem_req_data_ready toggling
        b_req_valid = 4'b0100; b_req_rw = 4'b0100; b_dvalid = 4'b0100;
        b_dmask[2*MB +: MB] = 16'hFFFF;
        b_dbits[2*DB +: DB] = 128'hA;
        step(); #1;
        chk("b_wr_valid", b_mreq_valid, 1);
        chk("b_wr_rw", b_mreq_rw, 1);
        chk("b_wr_tag", b_mreq_tag, 2);
        step();
        b_req_valid = 4'b0000;
        beat = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rdy = cyc[0];
            b_mdready = rdy;
            b_dbits[2*DB +: DB] = 128'hA + 128'(beat);
            #1;
            chk("b_wd_valid", b_mdvalid, 1);
            chk("b_wd_data", b_mdbits, 128'hA + 128'(beat));
            chk("b_wd_mask", b_mdmask, 16'hFFFF);
            chk("b_wd_cl_ready", b_dready, rdy ? 4'b0100 : 4'b0000);
            if (rdy) beat++;
            step();
            if (beat == 4) break;
        end
        chk("b_wd_beats", beat, 4);
        b_mdready = 1'b0;
        #1;
        chk("b_wd_done_dvalid", b_mdvalid, 0);
        chk("b_wd_done_state", dut_b.state_q, 0);
        chk("b_wd_done_mreq", b_mreq_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
